// File: rtl/mdr_mem_if.sv
`default_nettype none
// ============================================================================
// Module : mdr_mem_if
// Memory data register with request/acknowledge memory handshake controller,
// sub-word read extension, write byte enables and request timeout.
// Rev    : 1.0
// ============================================================================
module mdr_mem_if #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     i_bus_in,
    input  logic                 i_ld_bus,
    input  logic [ADDR_W-1:0]    i_mar,
    input  logic                 i_rd,
    input  logic                 i_wr,
    input  logic [1:0]           i_size,
    input  logic                 i_sgn,
    input  logic [WIDTH-1:0]     i_mem_rdata,
    input  logic                 i_mem_ack,
    output logic [WIDTH-1:0]     o_q,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [WIDTH-1:0]     o_mem_wdata,
    output logic [WIDTH/8-1:0]   o_mem_be,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int              BE_W  = WIDTH / 8;
    localparam int              CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_q;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic                r_sgn;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [BE_W-1:0]     w_be;

    // Bit-wise build avoids zero-width replications when WIDTH is 16.
    function automatic logic [WIDTH-1:0] f_extend(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       sz,
                                                  input logic             s);
        logic [WIDTH-1:0] r;
        r = d;
        for (int i = 8; i < WIDTH; i++) begin
            if (sz == 2'b10)
                r[i] = s & d[7];
            else if (sz == 2'b01 && i >= 16)
                r[i] = s & d[15];
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_sgn   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_ld_bus)
                        r_q <= i_bus_in;
                    if (i_rd || i_wr) begin
                        r_state <= i_rd ? S_RD : S_WR;
                        r_addr  <= i_mar;
                        r_size  <= i_size;
                        r_sgn   <= i_sgn;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD, S_WR: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (i_mem_ack) begin
                        if (r_state == S_RD)
                            r_q <= f_extend(i_mem_rdata, r_size, r_sgn);
                        r_state <= S_DONE;
                    end else if ((TIMEOUT > 0) && (r_cnt == C_TMO)) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_be = '0;
        for (int i = 0; i < BE_W; i++) begin
            w_be[i] = (r_state == S_WR) &&
                      ((r_size == 2'b00) || (r_size == 2'b11) ||
                       (r_size == 2'b01 && i < 2) || (i == 0));
        end
    end

    assign o_q         = r_q;
    assign o_mem_req   = (r_state == S_RD) || (r_state == S_WR);
    assign o_mem_we    = (r_state == S_WR);
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_q;
    assign o_mem_be    = w_be;
    assign o_busy      = (r_state == S_RD) || (r_state == S_WR);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdr_mem_if.sv
`default_nettype none
// ============================================================================
// Module : tb_mdr_mem_if
// Directed vector bench for mdr_mem_if (WIDTH=32, ADDR_W=9, TIMEOUT=15).
// Rev    : 1.0
// ============================================================================
module tb_mdr_mem_if;

    logic        clk;
    logic        clr;
    logic [31:0] i_bus_in;
    logic        i_ld_bus;
    logic [8:0]  i_mar;
    logic        i_rd;
    logic        i_wr;
    logic [1:0]  i_size;
    logic        i_sgn;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic [31:0] o_q;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [8:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    mdr_mem_if #(.WIDTH(32), .ADDR_W(9), .TIMEOUT(15)) u_dut (
        .clk         (clk),
        .clr         (clr),
        .i_bus_in    (i_bus_in),
        .i_ld_bus    (i_ld_bus),
        .i_mar       (i_mar),
        .i_rd        (i_rd),
        .i_wr        (i_wr),
        .i_size      (i_size),
        .i_sgn       (i_sgn),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack),
        .o_q         (o_q),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] data;
        int          wait_c;
        logic [31:0] exp_q;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[9];

    int total = 0;
    int bad   = 0;

    int          cap_busy;
    int          cap_done;
    logic        cap_we_first;
    logic        cap_we_all;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [8:0]  cap_addr;
    logic        cap_err_start;
    logic        cap_err_done;
    logic [31:0] q_before;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sets up the start inputs; edge 0 is the first tick here.
    task automatic run_access(input int wait_c, input logic [31:0] rdata);
        cap_busy = 0; cap_done = 0; cap_we_all = 1'b1; cap_we_first = 1'b0;
        cap_be = '0; cap_wdata = '0; cap_addr = '0; cap_err_start = 1'b0; cap_err_done = 1'b0;
        tick();
        i_rd = 1'b0; i_wr = 1'b0; i_ld_bus = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!o_busy && !o_done) break;
            if (o_busy) begin
                cap_busy++;
                cap_we_all = cap_we_all & o_mem_we;
                if (cap_busy == 1) begin
                    cap_we_first  = o_mem_we;
                    cap_be        = o_mem_be;
                    cap_wdata     = o_mem_wdata;
                    cap_addr      = o_mem_addr;
                    cap_err_start = o_err;
                end
            end
            if (o_done) begin
                cap_done++;
                cap_err_done = o_err;
            end
            i_mem_ack   = o_busy && (cap_busy == wait_c + 1);
            i_mem_rdata = rdata;
            tick();
        end
        i_mem_ack = 1'b0;
        chk("access_ends_idle", 64'(o_busy | o_done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 2'b10, 1'b1, 32'h1234_80F0, 0, 32'hFFFF_FFF0, 4'h0};
        vecs[1] = '{1'b0, 2'b10, 1'b0, 32'h1234_80F0, 1, 32'h0000_00F0, 4'h0};
        vecs[2] = '{1'b0, 2'b01, 1'b1, 32'h1234_80F0, 0, 32'hFFFF_80F0, 4'h0};
        vecs[3] = '{1'b0, 2'b01, 1'b0, 32'h1234_80F0, 2, 32'h0000_80F0, 4'h0};
        vecs[4] = '{1'b0, 2'b11, 1'b1, 32'h1234_80F0, 0, 32'h1234_80F0, 4'h0};
        vecs[5] = '{1'b0, 2'b10, 1'b1, 32'h0000_0070, 0, 32'h0000_0070, 4'h0};
        vecs[6] = '{1'b1, 2'b01, 1'b0, 32'hA5A5_0001, 2, 32'hA5A5_0001, 4'b0011};
        vecs[7] = '{1'b1, 2'b10, 1'b0, 32'h0000_7788, 0, 32'h0000_7788, 4'b0001};
        vecs[8] = '{1'b1, 2'b00, 1'b0, 32'h8765_4321, 1, 32'h8765_4321, 4'b1111};

        clr = 1'b0; i_bus_in = '0; i_ld_bus = 1'b0; i_mar = '0; i_rd = 1'b0; i_wr = 1'b0;
        i_size = 2'b00; i_sgn = 1'b0; i_mem_rdata = '0; i_mem_ack = 1'b0;

        #3;
        chk("rst_q",    64'(o_q), 64'd0);
        chk("rst_req",  64'(o_mem_req), 64'd0);
        chk("rst_we",   64'(o_mem_we), 64'd0);
        chk("rst_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err",  64'(o_err), 64'd0);
        chk("rst_be",   64'(o_mem_be), 64'd0);
        #10 clr = 1'b1;
        tick();

        // Word read, ack in the 4th RD cycle
        i_mar = 9'h05F; i_rd = 1'b1; i_size = 2'b00; i_sgn = 1'b0;
        run_access(3, 32'hDEAD_BEEF);
        chk("wrd_addr", 64'(cap_addr), 64'h05F);
        chk("wrd_q",    64'(o_q), 64'hDEAD_BEEF);
        chk("wrd_done", 64'(cap_done), 64'd1);
        chk("wrd_busy", 64'(cap_busy), 64'd4);
        chk("wrd_we",   64'(cap_we_first), 64'd0);

        for (int i = 0; i < 9; i++) begin
            i_mar  = 9'(i + 1);
            i_size = vecs[i].size;
            i_sgn  = vecs[i].sgn;
            if (vecs[i].wr) begin
                i_wr = 1'b1; i_ld_bus = 1'b1; i_bus_in = vecs[i].data;
            end else begin
                i_rd = 1'b1;
            end
            run_access(vecs[i].wait_c, vecs[i].data);
            chk($sformatf("vec%0d_q", i),    64'(o_q), 64'(vecs[i].exp_q));
            chk($sformatf("vec%0d_be", i),   64'(cap_be), 64'(vecs[i].exp_be));
            chk($sformatf("vec%0d_we", i),   64'(cap_we_first), 64'(vecs[i].wr));
            chk($sformatf("vec%0d_busy", i), 64'(cap_busy), 64'(vecs[i].wait_c + 1));
            chk($sformatf("vec%0d_done", i), 64'(cap_done), 64'd1);
            chk($sformatf("vec%0d_addr", i), 64'(cap_addr), 64'(i + 1));
            if (vecs[i].wr) begin
                chk($sformatf("vec%0d_wdata", i), 64'(cap_wdata), 64'(vecs[i].data));
                chk($sformatf("vec%0d_we_held", i), 64'(cap_we_all), 64'd1);
            end
        end

        // rd and wr together: read wins
        i_rd = 1'b1; i_wr = 1'b1; i_size = 2'b00; i_mar = 9'h020;
        run_access(0, 32'h0BAD_F00D);
        chk("rdwr_we", 64'(cap_we_first), 64'd0);
        chk("rdwr_be", 64'(cap_be), 64'd0);
        chk("rdwr_q",  64'(o_q), 64'h0BAD_F00D);

        // Timeout with no ack
        q_before = 32'h0BAD_F00D;
        i_rd = 1'b1; i_mar = 9'h1FF;
        run_access(1000, 32'h5555_5555);
        chk("tmo_busy",     64'(cap_busy), 64'd16);
        chk("tmo_done",     64'(cap_done), 64'd1);
        chk("tmo_err_done", 64'(cap_err_done), 64'd1);
        chk("tmo_q",        64'(o_q), 64'(q_before));
        chk("tmo_err_held", 64'(o_err), 64'd1);
        i_rd = 1'b1; i_mar = 9'h000;
        run_access(0, 32'h0000_0042);
        chk("tmo_err_clr", 64'(cap_err_start), 64'd0);
        chk("tmo_next_q",  64'(o_q), 64'h0000_0042);

        // wr and ld_bus during RD are ignored
        i_rd = 1'b1; i_mar = 9'h033; i_size = 2'b00;
        tick();
        i_rd = 1'b0; i_wr = 1'b1; i_ld_bus = 1'b1; i_bus_in = 32'hCAFE_CAFE;
        tick();
        chk("ign_busy", 64'(o_busy), 64'd1);
        chk("ign_we",   64'(o_mem_we), 64'd0);
        chk("ign_q",    64'(o_q), 64'h0000_0042);
        i_wr = 1'b0; i_ld_bus = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_2222;
        tick();
        i_mem_ack = 1'b0;
        chk("ign_done", 64'(o_done), 64'd1);
        chk("ign_rq",   64'(o_q), 64'h1111_2222);
        chk("ign_addr", 64'(o_mem_addr), 64'h033);
        tick();
        chk("ign_idle", 64'(o_busy | o_done), 64'd0);

        // Back-to-back: rd in DONE starts at once
        i_rd = 1'b1; i_mar = 9'h100;
        tick();
        i_rd = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hAAAA_0001;
        tick();
        i_mem_ack = 1'b0;
        chk("b2b_done1", 64'(o_done), 64'd1);
        i_rd = 1'b1; i_mar = 9'h101;
        tick();
        i_rd = 1'b0;
        chk("b2b_busy", 64'(o_busy), 64'd1);
        chk("b2b_ndone", 64'(o_done), 64'd0);
        chk("b2b_addr", 64'(o_mem_addr), 64'h101);
        chk("b2b_q1",   64'(o_q), 64'hAAAA_0001);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hBBBB_0002;
        tick();
        i_mem_ack = 1'b0;
        chk("b2b_done2", 64'(o_done), 64'd1);
        chk("b2b_q2",    64'(o_q), 64'hBBBB_0002);
        tick();

        // Asynchronous reset mid-RD
        i_rd = 1'b1; i_mar = 9'h0AA;
        tick();
        i_rd = 1'b0;
        chk("mid_pre_busy", 64'(o_busy), 64'd1);
        #2 clr = 1'b0;
        #1;
        chk("mid_req",  64'(o_mem_req), 64'd0);
        chk("mid_we",   64'(o_mem_we), 64'd0);
        chk("mid_busy", 64'(o_busy), 64'd0);
        chk("mid_done", 64'(o_done), 64'd0);
        chk("mid_q",    64'(o_q), 64'd0);
        chk("mid_addr", 64'(o_mem_addr), 64'd0);
        chk("mid_err",  64'(o_err), 64'd0);
        #2 clr = 1'b1;
        tick();
        chk("mid_after", 64'(o_busy | o_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
